// File: rtl/uart_tx_burst_fifo_pkg.sv
// Shared UART package: widths, depth and the TX FIFO state type.
// The state type is kept here so the RX buffer can reuse it.
package uart_pkg;

    localparam int UART_BYTE_W     = 8;
    localparam int UART_FIFO_DEPTH = 16;
    localparam int UART_FLAT_W     = 128;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP
    } tx_fifo_state_t;

    // Clamp a requested byte count to the buffer depth.
    function automatic logic [4:0] sat_count(input logic [4:0] c);
        return (c > 5'd16) ? 5'd16 : c;
    endfunction

endpackage

// File: rtl/uart_tx_burst_fifo_if.sv
// Byte stream handshake from the burst FIFO to the UART transmitter.
// master = FIFO side, slave = transmitter side.
interface uart_tx_burst_fifo_if import uart_pkg::*; ();

    logic                   tx_valid;
    logic [UART_BYTE_W-1:0] tx_data;
    logic                   tx_ready;

    modport master (
        output tx_valid,
        output tx_data,
        input  tx_ready
    );

    modport slave (
        input  tx_valid,
        input  tx_data,
        output tx_ready
    );

endinterface

// File: rtl/uart_tx_burst_fifo.sv
// Burst TX FIFO: loads up to 16 bytes in one strobe, then drains
// them in order over a valid/ready stream with optional idle gaps.
module uart_tx_burst_fifo import uart_pkg::*; #(
    parameter int GAP_CYCLES = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_load,
    input  logic [UART_FLAT_W-1:0] i_load_data_flat,
    input  logic [4:0]             i_load_count,
    input  logic                   i_abort,
    uart_tx_burst_fifo_if.master   tx,
    output logic [4:0]             o_count,
    output logic                   o_busy,
    output logic                   o_empty,
    output logic                   o_done,
    output logic                   o_load_err
);

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    tx_fifo_state_t         r_state;
    tx_fifo_state_t         w_state_nxt;
    logic [UART_BYTE_W-1:0] r_buf [UART_FIFO_DEPTH];
    logic [3:0]             r_rd_ptr;
    logic [3:0]             w_rd_nxt;
    logic [3:0]             w_rd_inc;
    logic [4:0]             r_count;
    logic [4:0]             w_count_nxt;
    logic                   r_tx_valid;
    logic                   w_valid_nxt;
    logic [UART_BYTE_W-1:0] r_tx_data;
    logic [UART_BYTE_W-1:0] w_data_nxt;
    logic                   r_done;
    logic                   w_done_nxt;
    logic                   r_load_err;
    logic                   w_lerr_nxt;
    logic                   r_busy;
    logic                   r_empty;
    logic [GW-1:0]          r_gap;
    logic [GW-1:0]          w_gap_nxt;
    logic                   w_hs;
    logic                   w_load_acc;

    assign w_hs       = r_tx_valid & tx.tx_ready;
    assign w_load_acc = (r_state == IDLE) & i_load
                      & (i_load_count != 5'd0) & ~i_abort;
    assign w_rd_inc   = r_rd_ptr + 4'd1;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state and next-value decode; abort overrides everything.
    always_comb begin
        w_state_nxt = r_state;
        w_rd_nxt    = r_rd_ptr;
        w_count_nxt = r_count;
        w_valid_nxt = r_tx_valid;
        w_data_nxt  = r_tx_data;
        w_done_nxt  = 1'b0;
        w_lerr_nxt  = 1'b0;
        w_gap_nxt   = r_gap;
        if (i_abort) begin
            w_state_nxt = IDLE;
            w_count_nxt = 5'd0;
            w_valid_nxt = 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_load_acc) begin
                        w_state_nxt = SEND;
                        w_count_nxt = sat_count(i_load_count);
                        w_rd_nxt    = 4'd0;
                        w_valid_nxt = 1'b1;
                        w_data_nxt  = i_load_data_flat[UART_BYTE_W-1:0];
                    end
                end
                SEND: begin
                    w_lerr_nxt = i_load;
                    if (w_hs) begin
                        w_rd_nxt    = w_rd_inc;
                        w_count_nxt = r_count - 5'd1;
                        w_data_nxt  = r_buf[w_rd_inc];
                        if (r_count == 5'd1) begin
                            w_state_nxt = IDLE;
                            w_valid_nxt = 1'b0;
                            w_done_nxt  = 1'b1;
                        end else if (GAP_CYCLES > 0) begin
                            w_state_nxt = GAP;
                            w_valid_nxt = 1'b0;
                            w_gap_nxt   = GW'(GAP_CYCLES - 1);
                        end
                    end
                end
                GAP: begin
                    w_lerr_nxt = i_load;
                    if (r_gap == '0) begin
                        w_state_nxt = SEND;
                        w_valid_nxt = 1'b1;
                    end else begin
                        w_gap_nxt = r_gap - GW'(1);
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // Datapath and status registers, all updated from the decoded next values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_ptr   <= 4'd0;
            r_count    <= 5'd0;
            r_tx_valid <= 1'b0;
            r_tx_data  <= '0;
            r_done     <= 1'b0;
            r_load_err <= 1'b0;
            r_busy     <= 1'b0;
            r_empty    <= 1'b1;
            r_gap      <= '0;
        end else begin
            r_rd_ptr   <= w_rd_nxt;
            r_count    <= w_count_nxt;
            r_tx_valid <= w_valid_nxt;
            r_tx_data  <= w_data_nxt;
            r_done     <= w_done_nxt;
            r_load_err <= w_lerr_nxt;
            r_busy     <= (w_state_nxt != IDLE);
            r_empty    <= (w_count_nxt == 5'd0);
            r_gap      <= w_gap_nxt;
        end
    end

    // Byte buffer: all 16 slots captured on an accepted load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < UART_FIFO_DEPTH; i++) r_buf[i] <= '0;
        end else if (w_load_acc) begin
            for (int i = 0; i < UART_FIFO_DEPTH; i++)
                r_buf[i] <= i_load_data_flat[i*UART_BYTE_W +: UART_BYTE_W];
        end
    end

    assign tx.tx_valid = r_tx_valid;
    assign tx.tx_data  = r_tx_data;
    assign o_count     = r_count;
    assign o_busy      = r_busy;
    assign o_empty     = r_empty;
    assign o_done      = r_done;
    assign o_load_err  = r_load_err;

endmodule

// File: tb/tb_uart_tx_burst_fifo.sv
// Bench for uart_tx_burst_fifo: two instances (no gap, 3-cycle gap)
// driven in lockstep and compared against a byte-list model.
module tb_uart_tx_burst_fifo;

    logic         clk = 1'b0;
    logic         reset;
    logic         load;
    logic         abort;
    logic [127:0] flat;
    logic [4:0]   lc;
    logic [1:0]   rdy;

    logic [4:0]   o_cnt  [2];
    logic         o_busy [2];
    logic         o_emp  [2];
    logic         o_done [2];
    logic         o_lerr [2];
    logic         vv     [2];
    logic [7:0]   vd     [2];

    int n_cmp = 0;
    int n_bad = 0;

    // Model: per instance a list of pending bytes (buffer + head + length),
    // remaining gap cycles, and the expected one-cycle pulses.
    logic [7:0] mb [2][16];
    int         mh [2];
    int         ml [2];
    int         mg [2];
    int         md [2];
    int         me [2];

    uart_tx_burst_fifo_if if0 ();
    uart_tx_burst_fifo_if if3 ();

    assign if0.tx_ready = rdy[0];
    assign if3.tx_ready = rdy[1];
    assign vv[0] = if0.tx_valid;
    assign vd[0] = if0.tx_data;
    assign vv[1] = if3.tx_valid;
    assign vd[1] = if3.tx_data;

    uart_tx_burst_fifo #(.GAP_CYCLES(0)) u_d0 (
        .clk              (clk),
        .reset            (reset),
        .i_load           (load),
        .i_load_data_flat (flat),
        .i_load_count     (lc),
        .i_abort          (abort),
        .tx               (if0),
        .o_count          (o_cnt[0]),
        .o_busy           (o_busy[0]),
        .o_empty          (o_emp[0]),
        .o_done           (o_done[0]),
        .o_load_err       (o_lerr[0])
    );

    uart_tx_burst_fifo #(.GAP_CYCLES(3)) u_d3 (
        .clk              (clk),
        .reset            (reset),
        .i_load           (load),
        .i_load_data_flat (flat),
        .i_load_count     (lc),
        .i_abort          (abort),
        .tx               (if3),
        .o_count          (o_cnt[1]),
        .o_busy           (o_busy[1]),
        .o_empty          (o_emp[1]),
        .o_done           (o_done[1]),
        .o_load_err       (o_lerr[1])
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h, want %0h", tag, $time, obs, exp);
        end
    endtask

    function automatic int gapv(input int k);
        return (k == 0) ? 0 : 3;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            ml[k] = 0; mh[k] = 0; mg[k] = 0; md[k] = 0; me[k] = 0;
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            bit ev;
            ev = (ml[k] > 0) && (mg[k] == 0);
            chk($sformatf("d%0d.valid", k), 32'(vv[k]), 32'(ev));
            chk($sformatf("d%0d.count", k), 32'(o_cnt[k]), 32'(ml[k]));
            chk($sformatf("d%0d.busy", k), 32'(o_busy[k]), 32'(ml[k] > 0));
            chk($sformatf("d%0d.empty", k), 32'(o_emp[k]), 32'(ml[k] == 0));
            chk($sformatf("d%0d.done", k), 32'(o_done[k]), 32'(md[k]));
            chk($sformatf("d%0d.lerr", k), 32'(o_lerr[k]), 32'(me[k]));
            if (ev) chk($sformatf("d%0d.data", k), 32'(vd[k]), 32'(mb[k][mh[k]]));
        end
    endtask

    // Advance the model by one clock edge using the current inputs.
    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            bit ev;
            ev = (ml[k] > 0) && (mg[k] == 0);
            if (reset || abort) begin
                ml[k] = 0; mh[k] = 0; mg[k] = 0; md[k] = 0; me[k] = 0;
            end else begin
                md[k] = 0;
                me[k] = 0;
                if (ml[k] == 0) begin
                    if (load && lc != 0) begin
                        ml[k] = (lc > 16) ? 16 : int'(lc);
                        mh[k] = 0;
                        mg[k] = 0;
                        for (int i = 0; i < 16; i++) mb[k][i] = flat[i*8 +: 8];
                    end
                end else begin
                    if (load) me[k] = 1;
                    if (mg[k] > 0) begin
                        mg[k]--;
                    end else if (ev && rdy[k]) begin
                        mh[k] = (mh[k] + 1) % 16;
                        ml[k]--;
                        if (ml[k] == 0) md[k] = 1;
                        else mg[k] = gapv(k);
                    end
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_all();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        reset = 1'b1; load = 1'b0; abort = 1'b0;
        flat = '0; lc = 5'd0; rdy = 2'b00;
        model_clear();
        #2;
        chk("rst.data0", 32'(vd[0]), 32'h0);
        chk("rst.data3", 32'(vd[1]), 32'h0);
        ticks(2);
        reset = 1'b0;
        ticks(1);

        // Three bytes, back-to-back drain.
        flat = 128'h030201; lc = 5'd3; load = 1'b1; rdy = 2'b11;
        tick();
        load = 1'b0;
        ticks(16);

        // Full 16-byte load, ready toggling.
        for (int i = 0; i < 16; i++) flat[i*8 +: 8] = 8'(i);
        lc = 5'd16; load = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 100; i++) begin
            rdy = (i % 2 == 0) ? 2'b00 : 2'b11;
            tick();
        end

        // Two bytes with ready held high.
        flat = {4{$urandom}}; lc = 5'd2; load = 1'b1; rdy = 2'b11;
        tick();
        load = 1'b0;
        ticks(12);

        // Second load while the first burst is draining.
        flat = {4{$urandom}}; lc = 5'd4; load = 1'b1;
        tick();
        load = 1'b0;
        tick();
        flat = {4{$urandom}}; load = 1'b1;
        tick();
        load = 1'b0;
        ticks(24);

        // Abort together with the first handshake, then reload.
        flat = {4{$urandom}}; lc = 5'd5; load = 1'b1;
        tick();
        load = 1'b0; abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
        flat = {4{$urandom}}; lc = 5'd2; load = 1'b1;
        tick();
        load = 1'b0;
        ticks(12);

        // Asynchronous reset in the middle of a 7-byte burst.
        flat = {4{$urandom}}; lc = 5'd7; load = 1'b1; rdy = 2'b00;
        tick();
        load = 1'b0;
        ticks(2);
        reset = 1'b1;
        #2;
        chk("arst.cnt", 32'(o_cnt[0]), 32'd0);
        chk("arst.valid", 32'(vv[1]), 32'd0);
        chk("arst.data", 32'(vd[0]), 32'h0);
        chk("arst.empty", 32'(o_emp[1]), 32'd1);
        model_clear();
        tick();
        reset = 1'b0; load = 1'b1; lc = 5'd0;
        tick();
        load = 1'b0;
        ticks(3);

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            load  = ($urandom % 5) == 0;
            lc    = 5'($urandom);
            flat  = {$urandom, $urandom, $urandom, $urandom};
            abort = ($urandom % 40) == 0;
            rdy   = 2'($urandom);
            if (($urandom % 700) == 0) begin
                reset = 1'b1;
                model_clear();
            end else begin
                reset = 1'b0;
            end
            tick();
        end
        reset = 1'b0; load = 1'b0; abort = 1'b0;
        ticks(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
